// File: rtl/uart_link_pkg.sv
// Shared types for the UART loopback link scheduler: FSM states, transfer direction
// and the per-direction enable pattern.
package uart_link_pkg;

    typedef enum logic [2:0] {IDLE, GRANT, LAUNCH, WAIT, DONE, ERR} link_state_e;
    typedef enum logic {DIR_A, DIR_B} dir_e;

    // Enable pattern ordered {en_tx1, en_rx1, en_tx2, en_rx2}
    function automatic logic [3:0] dir_enables(input dir_e d);
        return (d == DIR_A) ? 4'b1001 : 4'b0110;
    endfunction

endpackage

// File: rtl/uart_link_sched_if.sv
// Requester-side handshake bundle of the link scheduler: two request/grant/done
// channels plus the shared received-byte and status outputs.
interface uart_link_sched_if;

    logic       req_a;
    logic [7:0] din_a;
    logic       gnt_a;
    logic       done_a;
    logic       req_b;
    logic [7:0] din_b;
    logic       gnt_b;
    logic       done_b;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       err_tmo;

    modport master (
        output req_a, din_a, req_b, din_b,
        input  gnt_a, done_a, gnt_b, done_b, rx_data, rx_valid, busy, err_tmo
    );

    modport slave (
        input  req_a, din_a, req_b, din_b,
        output gnt_a, done_a, gnt_b, done_b, rx_data, rx_valid, busy, err_tmo
    );

endinterface

// File: rtl/uart_link_rr_arb.sv
// Two-way round-robin arbiter: bit 0 is requester A, bit 1 is requester B.
// The pointer remembers who was served last so the other side wins a tie.
module uart_link_rr_arb
    import uart_link_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    dir_e last_served;

    always_comb begin
        grant = req;
        if (req == 2'b11)
            grant = (last_served == DIR_B) ? 2'b01 : 2'b10;
    end

    // Reset to B so that A wins the very first tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_served <= DIR_B;
        else if (advance && (grant != 2'b00))
            last_served <= grant[1] ? DIR_B : DIR_A;
    end

endmodule

// File: rtl/uart_link_sched.sv
// Scheduler for the uart1<->uart2 loopback pair: arbitrates A/B, sequences enables and
// newd, waits for tx/rx completion. Define UART_LINK_TMO_EN to enable the WAIT watchdog.
module uart_link_sched
    import uart_link_pkg::*;
#(
    parameter int CLK_FREQ    = 1000000,
    parameter int BAUD_RATE   = 9600,
    parameter int TIMEOUT_CYC = 24 * (CLK_FREQ / BAUD_RATE)
) (
    input  logic                clk,
    input  logic                rst,
    uart_link_sched_if.slave    req_if,
    output logic                newd,
    output logic [7:0]          din,
    output logic                en_tx1,
    output logic                en_rx1,
    output logic                en_tx2,
    output logic                en_rx2,
    input  logic                donetx1,
    input  logic                donetx2,
    input  logic                donerx1,
    input  logic                donerx2,
    input  logic [7:0]          dout
);

    link_state_e state, state_nxt;
    dir_e        dir;
    logic [7:0]  din_r;
    logic [7:0]  cap_r;
    logic [7:0]  rx_data_r;
    logic        tx_seen, rx_seen;
    logic        sel_tx, sel_rx;
    logic        tx_nxt, rx_nxt;
    logic [1:0]  grant;

    uart_link_rr_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({req_if.req_b, req_if.req_a}),
        .advance (state == IDLE),
        .grant   (grant)
    );

    // Only the strobes belonging to the active direction count
    assign sel_tx = (dir == DIR_A) ? donetx1 : donetx2;
    assign sel_rx = (dir == DIR_A) ? donerx2 : donerx1;
    assign tx_nxt = tx_seen | sel_tx;
    assign rx_nxt = rx_seen | sel_rx;
    assign din    = din_r;

`ifdef UART_LINK_TMO_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Counter is zero during LAUNCH and counts every cycle from there on
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tmo_cnt <= '0;
        else if (state == LAUNCH || state == WAIT)
            tmo_cnt <= tmo_cnt + 1'b1;
        else
            tmo_cnt <= '0;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant != 2'b00) state_nxt = GRANT;
            GRANT:   state_nxt = LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT: begin
                if (tx_nxt && rx_nxt)
                    state_nxt = DONE;
`ifdef UART_LINK_TMO_EN
                else if (tmo_cnt == TMO_W'(TIMEOUT_CYC))
                    state_nxt = ERR;
`endif
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_if.gnt_a    = 1'b0;
        req_if.gnt_b    = 1'b0;
        req_if.done_a   = 1'b0;
        req_if.done_b   = 1'b0;
        req_if.rx_valid = 1'b0;
        req_if.rx_data  = rx_data_r;
        req_if.err_tmo  = 1'b0;
        req_if.busy     = (state != IDLE);
        newd            = 1'b0;
        {en_tx1, en_rx1, en_tx2, en_rx2} = 4'b0000;
        case (state)
            GRANT: begin
                req_if.gnt_a = (dir == DIR_A);
                req_if.gnt_b = (dir == DIR_B);
                {en_tx1, en_rx1, en_tx2, en_rx2} = dir_enables(dir);
            end
            LAUNCH: begin
                newd = 1'b1;
                {en_tx1, en_rx1, en_tx2, en_rx2} = dir_enables(dir);
            end
            WAIT: begin
                {en_tx1, en_rx1, en_tx2, en_rx2} = dir_enables(dir);
            end
            DONE: begin
                req_if.done_a   = (dir == DIR_A);
                req_if.done_b   = (dir == DIR_B);
                req_if.rx_valid = 1'b1;
                req_if.rx_data  = cap_r;
            end
`ifdef UART_LINK_TMO_EN
            ERR: req_if.err_tmo = 1'b1;
`endif
            default: ;
        endcase
    end

    // Direction is fixed at the IDLE decision; payload is taken in the grant cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir       <= DIR_A;
            din_r     <= 8'h00;
            cap_r     <= 8'h00;
            rx_data_r <= 8'h00;
            tx_seen   <= 1'b0;
            rx_seen   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (grant != 2'b00) dir <= grant[1] ? DIR_B : DIR_A;
                GRANT: begin
                    din_r   <= (dir == DIR_A) ? req_if.din_a : req_if.din_b;
                    tx_seen <= 1'b0;
                    rx_seen <= 1'b0;
                end
                WAIT: begin
                    tx_seen <= tx_nxt;
                    rx_seen <= rx_nxt;
                    if (sel_rx && !rx_seen)
                        cap_r <= dout;
                end
                DONE: begin
                    rx_data_r <= cap_r;
                    tx_seen   <= 1'b0;
                    rx_seen   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
